// File: rtl/adder_8bit.sv
// Purpose : unsigned 8-bit ripple-carry adder with carry-in, plus a one-cycle registered copy of the result.
// Latency : sum/overflow are combinational; *_reg outputs follow one clk edge later; one result per cycle.
// Backpressure: none -- no handshake, the output registers load on every rising edge.
//
// Ports:
//   clk, rst      - output-stage clock and asynchronous active-high reset
//   a, b          - 8-bit unsigned operands
//   carry_in      - carry into bit 0
//   sum, overflow - combinational {overflow, sum} = a + b + carry_in
//   sum_reg, overflow_reg - sum/overflow registered one cycle
//   zero_reg, sovf_reg    - registered zero and two's-complement overflow flags,
//                           present only when ADDER_8BIT_STATUS_EN is defined
module adder_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow,
    output logic [7:0] sum_reg,
    output logic       overflow_reg
`ifdef ADDER_8BIT_STATUS_EN
    ,
    output logic       zero_reg,
    output logic       sovf_reg
`endif
);

    // Ripple chain: w_carry[i] is the carry into bit i, w_carry[8] is the carry-out.
    logic [8:0] w_carry;
    logic [7:0] w_sum;

    assign w_carry[0] = carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        // Majority of the three inputs generates the carry into the next bit.
        assign w_carry[i + 1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end

    assign sum      = w_sum;
    assign overflow = w_carry[8];

    logic [7:0] r_sum;
    logic       r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum      <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_overflow <= w_carry[8];
        end
    end

    assign sum_reg      = r_sum;
    assign overflow_reg = r_overflow;

`ifdef ADDER_8BIT_STATUS_EN
    logic w_zero;
    logic w_sovf;
    logic r_zero;
    logic r_sovf;

    assign w_zero = (w_sum == 8'h00);
    // Signed overflow: operands share a sign but the result's sign differs.
    assign w_sovf = (a[7] == b[7]) && (w_sum[7] != a[7]);

    // Reset value of zero_reg is 1 so it stays consistent with the cleared sum_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b1;
            r_sovf <= 1'b0;
        end else begin
            r_zero <= w_zero;
            r_sovf <= w_sovf;
        end
    end

    assign zero_reg = r_zero;
    assign sovf_reg = r_sovf;
`endif

endmodule

// File: tb/tb_adder_8bit.sv
module tb_adder_8bit;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic [7:0] sum;
    logic       overflow;
    logic [7:0] sum_reg;
    logic       overflow_reg;
`ifdef ADDER_8BIT_STATUS_EN
    logic       zero_reg;
    logic       sovf_reg;
`endif

    int n_vec;
    int n_err;

    adder_8bit dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .sum          (sum),
        .overflow     (overflow),
        .sum_reg      (sum_reg),
        .overflow_reg (overflow_reg)
`ifdef ADDER_8BIT_STATUS_EN
        ,
        .zero_reg     (zero_reg),
        .sovf_reg     (sovf_reg)
`endif
    );

    // 10 ns clock; it can be parked low so the combinational sweep burns no cycles.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish by 3 ms");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sum_reg !== 8'h00 || overflow_reg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: sum_reg=%h overflow_reg=%b, want 00 0", sum_reg, overflow_reg);
        end
`ifdef ADDER_8BIT_STATUS_EN
        n_vec++;
        if (zero_reg !== 1'b1 || sovf_reg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: zero_reg=%b sovf_reg=%b, want 1 0", zero_reg, sovf_reg);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_exhaustive;
        logic [8:0] exp;
        int         bad;
        bad = 0;
        @(negedge clk);
        clk_run = 1'b0;
        for (int i = 0; i < (1 << 17); i++) begin
            a        = i[7:0];
            b        = i[15:8];
            carry_in = i[16];
            exp      = {1'b0, a} + {1'b0, b} + {8'h00, carry_in};
            #9;
            n_vec++;
            if (sum !== exp[7:0] || overflow !== exp[8]) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL exhaustive a=%h b=%h cin=%b: sum=%h ovf=%b, want %h %b",
                             a, b, carry_in, sum, overflow, exp[7:0], exp[8]);
                bad++;
            end
            #1;
        end
        clk_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_boundaries;
        logic [7:0] va  [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb  [3] = '{8'h00, 8'hFF, 8'h00};
        logic       vc  [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] es  [3] = '{8'h00, 8'hFF, 8'h00};
        logic       eo  [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k]; carry_in = vc[k];
            #1;
            n_vec++;
            if (sum !== es[k] || overflow !== eo[k]) begin
                n_err++;
                $display("FAIL boundary%0d: sum=%h ovf=%b, want %h %b", k, sum, overflow, es[k], eo[k]);
            end
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        a = 8'h12; b = 8'h34; carry_in = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (sum_reg !== 8'h47 || overflow_reg !== 1'b0) begin
            n_err++;
            $display("FAIL latency: sum_reg=%h overflow_reg=%b, want 47 0", sum_reg, overflow_reg);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4] = '{8'h0F, 8'hFF, 8'hAA, 8'h80};
        logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h55, 8'h7F};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [4] = '{8'h10, 8'h00, 8'h00, 8'hFF};
        logic       eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = va[k]; b = vb[k]; carry_in = vc[k];
            @(posedge clk);
            #1;
            n_vec++;
            if (sum_reg !== es[k] || overflow_reg !== eo[k]) begin
                n_err++;
                $display("FAIL back_to_back%0d: sum_reg=%h overflow_reg=%b, want %h %b",
                         k, sum_reg, overflow_reg, es[k], eo[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        a = 8'h80; b = 8'h80; carry_in = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (sum_reg !== 8'h00 || overflow_reg !== 1'b1) begin
            n_err++;
            $display("FAIL arst_preload: sum_reg=%h overflow_reg=%b, want 00 1", sum_reg, overflow_reg);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (sum_reg !== 8'h00 || overflow_reg !== 1'b0) begin
            n_err++;
            $display("FAIL arst_immediate: sum_reg=%h overflow_reg=%b, want 00 0", sum_reg, overflow_reg);
        end
        n_vec++;
        if (sum !== 8'h00 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL arst_comb_live: sum=%h overflow=%b, want 00 1", sum, overflow);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (overflow_reg !== 1'b0) begin
            n_err++;
            $display("FAIL arst_hold: overflow_reg=%b, want 0", overflow_reg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (sum_reg !== 8'h00 || overflow_reg !== 1'b1) begin
            n_err++;
            $display("FAIL arst_release: sum_reg=%h overflow_reg=%b, want 00 1", sum_reg, overflow_reg);
        end
    endtask

`ifdef ADDER_8BIT_STATUS_EN
    task automatic test_status;
        logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h01};
        logic [7:0] vb [3] = '{8'h01, 8'h80, 8'hFF};
        logic       ez [3] = '{1'b0, 1'b1, 1'b1};
        logic       ev [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = va[k]; b = vb[k]; carry_in = 1'b0;
            @(posedge clk);
            #1;
            n_vec++;
            if (zero_reg !== ez[k] || sovf_reg !== ev[k]) begin
                n_err++;
                $display("FAIL status%0d: zero_reg=%b sovf_reg=%b, want %b %b",
                         k, zero_reg, sovf_reg, ez[k], ev[k]);
            end
        end
    endtask
`endif

    initial begin
        n_vec    = 0;
        n_err    = 0;
        clk_run  = 1'b1;
        rst      = 1'b1;
        a        = 8'h00;
        b        = 8'h00;
        carry_in = 1'b0;

        test_reset();
        test_exhaustive();
        test_boundaries();
        test_latency();
        test_back_to_back();
        test_async_reset();
`ifdef ADDER_8BIT_STATUS_EN
        test_status();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
